// File: rtl/vga_sprite_pkg.sv
// rtl/vga_sprite_pkg.sv - shared VGA/sprite constants, win animation state type and counter sizing helper
package vga_sprite_pkg;

  localparam int H_ACTIVE    = 640;
  localparam int V_ACTIVE    = 480;
  localparam int SPRITE_SIZE = 32;
  localparam int X_CENTER    = 304;
  localparam int Y_CENTER    = 224;

  // Rightmost legal left column so the sprite stays fully on screen.
  localparam int X_MAX       = H_ACTIVE - SPRITE_SIZE;

  typedef enum logic [2:0] {
    IDLE,
    DROP,
    BOUNCE,
    BLINK,
    DONE
  } win_anim_state_t;

  // Width of a counter able to hold the largest of the animation frame counts.
  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return (m < 2) ? 1 : $clog2(m + 1);
  endfunction

endpackage

// File: rtl/frame_tick_gen.sv
// rtl/frame_tick_gen.sv - one-cycle frame tick at the first vertical blank line
module frame_tick_gen
  import vga_sprite_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] h_count,
  input  logic [9:0] v_count,
  output logic       tick
);

  logic match;
  logic match_q;

  assign match = (h_count == 10'd0) && (v_count == 10'(V_ACTIVE));

  // Register the decode and emit a single pulse even if the counters dwell on the match.
  always_ff @(posedge clk) begin
    if (rst) begin
      match_q <= 1'b0;
      tick    <= 1'b0;
    end else begin
      match_q <= match;
      tick    <= match && !match_q;
    end
  end

endmodule

// File: rtl/win_sprite_animator.sv
// rtl/win_sprite_animator.sv - win sprite animation sequencer; blink phase enabled by WIN_ANIM_BLINK_EN
module win_sprite_animator
  import vga_sprite_pkg::*;
#(
  parameter int STEP          = 4,
  parameter int BOUNCE_FRAMES = 120,
  parameter int BLINK_PERIOD  = 8,
  parameter int BLINK_COUNT   = 6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] h_count,
  input  logic [9:0] v_count,
  input  logic       start,
  input  logic       abort,
  output logic [9:0] x_pos,
  output logic [9:0] y_pos,
  output logic       show,
  output logic       busy,
  output logic       done
);

  localparam int CNT_W = cnt_width(BOUNCE_FRAMES, BLINK_PERIOD, BLINK_COUNT);

  localparam logic [9:0]        X_CENTER_V = 10'(X_CENTER);
  localparam logic [9:0]        Y_CENTER_V = 10'(Y_CENTER);
  localparam logic [9:0]        X_MAX_V    = 10'(X_MAX);
  localparam logic signed [10:0] X_MAX_S   = 11'(X_MAX);
  localparam logic signed [10:0] STEP_S    = 11'(STEP);

  win_anim_state_t state;
  win_anim_state_t state_next;

  logic             tick;
  logic [CNT_W-1:0] frame_cnt;
  logic             dx_pos;

  logic [10:0]        y_sum;
  logic               drop_end;
  logic signed [10:0] x_ext;
  logic signed [10:0] x_sum;
  logic               hit_hi;
  logic               hit_lo;
  logic               bounce_end;
  logic               restart;

  frame_tick_gen u_tick (
    .clk     (clk),
    .rst     (rst),
    .h_count (h_count),
    .v_count (v_count),
    .tick    (tick)
  );

  assign y_sum    = {1'b0, y_pos} + 11'(STEP);
  assign drop_end = (y_sum >= 11'(Y_CENTER));

  // Signed 11-bit so a step below column 0 is visible as a negative result.
  assign x_ext  = $signed({1'b0, x_pos});
  assign x_sum  = dx_pos ? (x_ext + STEP_S) : (x_ext - STEP_S);
  // Reaching an edge exactly also reverses, so the sprite turns on the wall rather than one frame later.
  assign hit_hi = (x_sum >= X_MAX_S);
  assign hit_lo = (x_sum <= 11'sd0);

  assign bounce_end = (frame_cnt == CNT_W'(BOUNCE_FRAMES - 1));
  assign restart    = start && ((state == IDLE) || (state == DONE));

`ifdef WIN_ANIM_BLINK_EN
  logic [CNT_W-1:0] toggle_cnt;
  logic             blink_flip;
  logic             blink_end;

  assign blink_flip = (frame_cnt == CNT_W'(BLINK_PERIOD - 1));
  assign blink_end  = blink_flip && (toggle_cnt == CNT_W'(BLINK_COUNT - 1));
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state decode; abort overrides everything, start only counts when idle or finished.
  always_comb begin
    state_next = state;
    if (abort) begin
      state_next = IDLE;
    end else begin
      unique case (state)
        IDLE, DONE: if (start) state_next = DROP;
        DROP:       if (tick && drop_end) state_next = BOUNCE;
`ifdef WIN_ANIM_BLINK_EN
        BOUNCE:     if (tick && bounce_end) state_next = BLINK;
        BLINK:      if (tick && blink_end) state_next = DONE;
`else
        BOUNCE:     if (tick && bounce_end) state_next = DONE;
        BLINK:      state_next = IDLE;
`endif
        default:    state_next = IDLE;
      endcase
    end
  end

  // Status flags decoded from the registered state.
  always_comb begin
    busy = (state == DROP) || (state == BOUNCE) || (state == BLINK);
    done = (state == DONE);
  end

  // Position, visibility and frame counting; everything moves only on a frame tick.
  always_ff @(posedge clk) begin
    if (rst || abort) begin
      x_pos      <= X_CENTER_V;
      y_pos      <= 10'd0;
      show       <= 1'b0;
      dx_pos     <= 1'b1;
      frame_cnt  <= '0;
`ifdef WIN_ANIM_BLINK_EN
      toggle_cnt <= '0;
`endif
    end else if (restart) begin
      // A tick coinciding with start is deliberately dropped here.
      x_pos      <= X_CENTER_V;
      y_pos      <= 10'd0;
      show       <= 1'b1;
      dx_pos     <= 1'b1;
      frame_cnt  <= '0;
`ifdef WIN_ANIM_BLINK_EN
      toggle_cnt <= '0;
`endif
    end else if (tick) begin
      unique case (state)
        DROP: begin
          if (drop_end) begin
            y_pos     <= Y_CENTER_V;
            frame_cnt <= '0;
          end else begin
            y_pos <= y_sum[9:0];
          end
        end
        BOUNCE: begin
          if (bounce_end) begin
            x_pos     <= X_CENTER_V;
            frame_cnt <= '0;
`ifdef WIN_ANIM_BLINK_EN
            toggle_cnt <= '0;
`endif
          end else begin
            frame_cnt <= frame_cnt + 1'b1;
            if (hit_hi) begin
              x_pos  <= X_MAX_V;
              dx_pos <= 1'b0;
            end else if (hit_lo) begin
              x_pos  <= 10'd0;
              dx_pos <= 1'b1;
            end else begin
              x_pos <= x_sum[9:0];
            end
          end
        end
`ifdef WIN_ANIM_BLINK_EN
        BLINK: begin
          if (blink_flip) begin
            frame_cnt  <= '0;
            toggle_cnt <= toggle_cnt + 1'b1;
            // The last toggle lands in DONE, where the sprite is always visible.
            show       <= blink_end ? 1'b1 : !show;
          end else begin
            frame_cnt <= frame_cnt + 1'b1;
          end
        end
`endif
        DONE:    show <= 1'b1;
        default: ;
      endcase
    end
  end

endmodule
